// File: rtl/heatmap_row_writer.sv
// Grid row consumer: latches one row of NCOLS fixed-point node values, re-arms the grid,
// then paints the row into the VGA pixel buffer as CELLxCELL RGB332 squares.
module heatmap_row_writer #(
  parameter int NCOLS = 64,
  parameter int NROWS = 64,
  parameter int CELL  = 4,
  parameter int X0    = 64,
  parameter int Y0    = 16
) (
  input  logic                  clk_50,
  input  logic                  reset,
  input  logic                  grid_flag,
  input  logic [32*NCOLS-1:0]   node_bus,
  output logic                  grid_start,
  output logic [9:0]            pix_x,
  output logic [8:0]            pix_y,
  output logic [7:0]            pix_color,
  output logic                  pix_write,
  input  logic                  pix_waitrequest,
  output logic                  frame_done,
  output logic [5:0]            row_idx
);

  localparam int CW   = (CELL > 1) ? $clog2(CELL) : 1;
  localparam int COLW = (NCOLS > 1) ? $clog2(NCOLS) : 1;

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAW, DONE} state_t;

  state_t                    state, state_nxt;
  logic                      flag_s, flag_q, flag_rise, pending;
  logic [NCOLS-1:0][31:0]    row_buf;
  logic [COLW-1:0]           col;
  logic [CW-1:0]             sx, sy;
  logic                      draw, accept, sx_last, sy_last, last_cell;
  logic [31:0]               v;
  logic [7:0]                lvl;
  logic                      unused_frac;

  // grid_flag is registered once before edge detection, giving the 2-cycle flag->start latency
  assign flag_rise = flag_s & ~flag_q;
  assign draw      = (state == DRAW);
  assign accept    = draw & ~pix_waitrequest;
  assign sx_last   = (sx == CW'(CELL - 1));
  assign sy_last   = (sy == CW'(CELL - 1));
  assign last_cell = sx_last & sy_last & (col == COLW'(NCOLS - 1));

  always_ff @(posedge clk_50 or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    grid_start = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE:    if (flag_rise || pending) state_nxt = CAPTURE;
      CAPTURE: begin
        grid_start = 1'b1;
        state_nxt  = DRAW;
      end
      DRAW:    if (accept && last_cell) state_nxt = DONE;
      DONE: begin
        frame_done = (row_idx == 6'(NROWS - 1));
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_50 or negedge reset) begin
    if (!reset) begin
      flag_s  <= 1'b0;
      flag_q  <= 1'b0;
      pending <= 1'b0;
      row_buf <= '0;
      col     <= '0;
      sx      <= '0;
      sy      <= '0;
      row_idx <= '0;
    end else begin
      flag_s <= grid_flag;
      flag_q <= flag_s;
      // single-depth request memory: rises seen while busy collapse into one
      if (state == IDLE)  pending <= 1'b0;
      else if (flag_rise) pending <= 1'b1;
      case (state)
        CAPTURE: begin
          row_buf <= node_bus;
          col     <= '0;
          sx      <= '0;
          sy      <= '0;
        end
        DRAW: if (accept) begin
          if (sx_last) begin
            sx <= '0;
            if (sy_last) begin
              sy  <= '0;
              col <= col + 1'b1;
            end else sy <= sy + 1'b1;
          end else sx <= sx + 1'b1;
        end
        DONE: row_idx <= (row_idx == 6'(NROWS - 1)) ? 6'd0 : row_idx + 6'd1;
        default: ;
      endcase
    end
  end

  // 5.27 fixed point: clamp negatives to 0 and >=1.0 to full scale, else top 8 fraction bits
  assign v           = row_buf[col];
  assign unused_frac = ^v[18:0];

  always_comb begin
    if (v[31])          lvl = 8'h00;
    else if (|v[30:27]) lvl = 8'hFF;
    else                lvl = v[26:19];
  end

  assign pix_write = draw;
  assign pix_x     = draw ? 10'(X0 + int'(col) * CELL + int'(sx)) : 10'd0;
  assign pix_y     = draw ? 9'(Y0 + int'(row_idx) * CELL + int'(sy)) : 9'd0;
  assign pix_color = draw ? {lvl[7:5], lvl[7:6] ^ lvl[6:5], 1'b0, ~lvl[7:6]} : 8'd0;

endmodule

// File: tb/tb_heatmap_row_writer.sv
// Directed bench for heatmap_row_writer: a pixel-level scoreboard built from the row rules,
// checked on every accepted write, plus handshake, stall, frame and reset scenarios.
module tb_heatmap_row_writer;

  localparam int NC   = 64;
  localparam int NR   = 8;   // short frame keeps the full-frame wrap scenario quick
  localparam int CELL = 4;
  localparam int X0   = 64;
  localparam int Y0   = 16;

  logic              clk_50 = 1'b0;
  logic              reset = 1'b0;
  logic              grid_flag = 1'b0;
  logic [32*NC-1:0]  node_bus;
  logic              grid_start, pix_write, frame_done;
  logic [9:0]        pix_x;
  logic [8:0]        pix_y;
  logic [7:0]        pix_color;
  logic              pix_waitrequest = 1'b0;
  logic [5:0]        row_idx;

  logic [31:0] nodes [NC];
  bit          rand_wr = 1'b0;

  typedef struct { int x; int y; logic [7:0] c; bit last; int row; } px_t;
  px_t  exp_q[$];
  px_t  p;
  int   vectors = 0, miscompares = 0;
  int   acc_cnt = 0, gs_cnt = 0, fd_cnt = 0, model_row = 0;
  bit   prev_stall = 1'b0, fd_exp = 1'b0;
  logic [27:0] prev_out;

  heatmap_row_writer #(.NCOLS(NC), .NROWS(NR), .CELL(CELL), .X0(X0), .Y0(Y0)) dut (
    .clk_50(clk_50), .reset(reset), .grid_flag(grid_flag), .node_bus(node_bus),
    .grid_start(grid_start), .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color),
    .pix_write(pix_write), .pix_waitrequest(pix_waitrequest), .frame_done(frame_done),
    .row_idx(row_idx)
  );

  always #5 clk_50 = ~clk_50;

  always_comb begin
    node_bus = '0;
    for (int c = 0; c < NC; c++) node_bus[32*c +: 32] = nodes[c];
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // node value as a real number, clamped to [0,1), quantised to 1/256, then blue->red map
  function automatic logic [7:0] exp_color(logic [31:0] n);
    real v;
    int  i;
    logic [7:0] b;
    v = real'($signed(n)) / 134217728.0;
    if (v < 0.0)       i = 0;
    else if (v >= 1.0) i = 255;
    else               i = int'($floor(v * 256.0));
    b = i[7:0];
    return {b[7:5], b[7:6] ^ b[6:5], 1'b0, ~b[7:6]};
  endfunction

  initial forever begin
    @(posedge clk_50); #1;
    pix_waitrequest = rand_wr ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  always @(negedge clk_50) begin
    if (!reset) begin
      exp_q.delete();
      model_row  = 0;
      prev_stall = 1'b0;
      fd_exp     = 1'b0;
    end else begin
      if (fd_exp || frame_done) chk("frame_done", 32'(frame_done), 32'(fd_exp));
      if (frame_done) fd_cnt++;
      fd_exp = 1'b0;
      if (prev_stall) chk("stall_hold", 32'({pix_write, pix_x, pix_y, pix_color}), 32'(prev_out));
      prev_stall = pix_write && pix_waitrequest;
      prev_out   = {pix_write, pix_x, pix_y, pix_color};
      if (grid_start) begin
        gs_cnt++;
        for (int c = 0; c < NC; c++)
          for (int y = 0; y < CELL; y++)
            for (int x = 0; x < CELL; x++)
              exp_q.push_back('{X0 + c*CELL + x, Y0 + model_row*CELL + y, exp_color(nodes[c]),
                                (c == NC-1 && y == CELL-1 && x == CELL-1), model_row});
        model_row = (model_row + 1) % NR;
      end
      if (pix_write && !pix_waitrequest) begin
        acc_cnt++;
        if (exp_q.size() == 0) chk("spurious_write", 32'd1, 32'd0);
        else begin
          p = exp_q.pop_front();
          chk("pix_x", 32'(pix_x), 32'(p.x));
          chk("pix_y", 32'(pix_y), 32'(p.y));
          chk("pix_color", 32'(pix_color), 32'(p.c));
          fd_exp = p.last && (p.row == NR-1);
        end
      end
    end
  end

  task automatic do_row(output int lat);
    lat = -1;
    grid_flag = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk_50); #1;
      if (grid_start) begin lat = k; break; end
    end
    grid_flag = 1'b0;
    if (lat < 0) chk("grid_start_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    int quiet = 0;
    for (int k = 0; k < 20000 && quiet < 10; k++) begin
      @(posedge clk_50); #1;
      if (!pix_write && exp_q.size() == 0) quiet++;
      else quiet = 0;
    end
    chk("idle_timeout", 32'(quiet >= 10), 32'd1);
  endtask

  task automatic wait_acc(int target);
    for (int k = 0; k < 20000 && acc_cnt < target; k++) begin
      @(posedge clk_50); #1;
    end
    chk("accept_timeout", 32'(acc_cnt >= target), 32'd1);
  endtask

  initial begin
    int lat, a0, g0;
    for (int c = 0; c < NC; c++) nodes[c] = 32'h0800_0000;

    // palette pins against hand-worked RGB332 values
    chk("pal_one",   32'(exp_color(32'h0800_0000)), 32'hE0);
    chk("pal_big",   32'(exp_color(32'h7FFF_FFFF)), 32'hE0);
    chk("pal_zero",  32'(exp_color(32'h0000_0000)), 32'h03);
    chk("pal_neg",   32'(exp_color(32'hFC00_0000)), 32'h03);
    chk("pal_half",  32'(exp_color(32'h0400_0000)), 32'h91);

    repeat (3) @(posedge clk_50);
    #1;
    chk("reset_outs", 32'({grid_start, pix_write, frame_done, row_idx, pix_x, pix_y, pix_color}), 32'd0);
    reset = 1'b1;
    @(posedge clk_50); #1;

    // 1: all nodes 1.0
    a0 = acc_cnt; g0 = gs_cnt;
    do_row(lat);
    chk("start_latency", 32'(lat), 32'd2);
    @(posedge clk_50); #1;
    chk("first_write", 32'({pix_write, pix_x, pix_y, pix_color}), 32'({1'b1, 10'd64, 9'd16, 8'hE0}));
    wait_idle();
    chk("t1_writes", 32'(acc_cnt - a0), 32'd1024);
    chk("t1_starts", 32'(gs_cnt - g0), 32'd1);

    // 2: alternating -0.5 / +0.5
    for (int c = 0; c < NC; c++) nodes[c] = c[0] ? 32'h0400_0000 : 32'hFC00_0000;
    a0 = acc_cnt;
    do_row(lat);
    wait_idle();
    chk("t2_writes", 32'(acc_cnt - a0), 32'd1024);
    chk("t2_row_idx", 32'(row_idx), 32'd2);

    // 3: random backpressure
    for (int c = 0; c < NC; c++) nodes[c] = 32'(c) << 21;
    a0 = acc_cnt;
    rand_wr = 1'b1;
    do_row(lat);
    wait_idle();
    rand_wr = 1'b0;
    chk("t3_writes", 32'(acc_cnt - a0), 32'd1024);

    // 4: two further rises while drawing collapse into one extra row
    for (int c = 0; c < NC; c++) nodes[c] = 32'(c * 32'h0011_0000);
    a0 = acc_cnt; g0 = gs_cnt;
    do_row(lat);
    wait_acc(a0 + 200);
    grid_flag = 1'b1; repeat (3) @(posedge clk_50); #1; grid_flag = 1'b0;
    wait_acc(a0 + 400);
    grid_flag = 1'b1; repeat (3) @(posedge clk_50); #1; grid_flag = 1'b0;
    wait_idle();
    chk("t4_writes", 32'(acc_cnt - a0), 32'd2048);
    chk("t4_starts", 32'(gs_cnt - g0), 32'd2);

    // 5: finish the frame; values span negative, fractional and saturated
    for (int c = 0; c < NC; c++) nodes[c] = 32'(c - 8) << 24;
    for (int r = 0; r < 2*NR && fd_cnt == 0; r++) begin
      do_row(lat);
      wait_idle();
    end
    chk("t5_frame_pulses", 32'(fd_cnt), 32'd1);
    chk("t5_row_wrap", 32'(row_idx), 32'd0);

    // 6: reset in the middle of a row
    for (int c = 0; c < NC; c++) nodes[c] = $urandom;
    do_row(lat);
    wait_acc(acc_cnt + 300);
    @(posedge clk_50); #3;
    reset = 1'b0;
    grid_flag = 1'b0;
    #1;
    chk("t6_async_drop", 32'({pix_write, grid_start, row_idx, pix_x}), 32'd0);
    @(posedge clk_50); #1;
    reset = 1'b1;
    repeat (3) @(posedge clk_50);
    #1;
    chk("t6_idle_after", 32'({pix_write, grid_start, frame_done}), 32'd0);
    a0 = acc_cnt;
    do_row(lat);
    wait_idle();
    chk("t6_writes", 32'(acc_cnt - a0), 32'd1024);
    chk("t6_row_idx", 32'(row_idx), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
